// File: rtl/tqvp_dlmiles_i2c_seq_pkg.sv
// rtl/tqvp_dlmiles_i2c_seq_pkg.sv - shared encodings for the I2C transaction sequencer
package tqvp_dlmiles_i2c_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_START = 3'd1,
    CMD_WRITE = 3'd2,
    CMD_READ  = 3'd3,
    CMD_STOP  = 3'd4
  } cmd_e;

  localparam logic DIR_TXD = 1'b0;
  localparam logic DIR_RXD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FETCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  typedef struct packed {
    cmd_e       cmd;
    logic [7:0] wdata;
    logic       nack;
  } phy_req_t;

  // A read entry carries its NACK-this-byte flag in data[0].
  function automatic phy_req_t decode_txd(input logic [8:0] ent);
    phy_req_t r;
    r.cmd   = (ent[8] == DIR_RXD) ? CMD_READ : CMD_WRITE;
    r.wdata = ent[7:0];
    r.nack  = (ent[8] == DIR_RXD) && ent[0];
    return r;
  endfunction

endpackage

// File: rtl/tqvp_dlmiles_i2c_seq_if.sv
// rtl/tqvp_dlmiles_i2c_seq_if.sv - command/completion bus between sequencer and byte-level PHY
interface tqvp_dlmiles_i2c_seq_if;
  logic [2:0] phy_cmd_o;
  logic       phy_nack_o;
  logic [7:0] phy_wdata_o;
  logic       phy_cmd_valid_o;
  logic       phy_cmd_ready_i;
  logic       phy_done_i;
  logic       phy_ack_i;
  logic [7:0] phy_rdata_i;
  logic       phy_arb_lost_i;
  logic       phy_abort_o;

  modport master (
    output phy_cmd_o, phy_nack_o, phy_wdata_o, phy_cmd_valid_o, phy_abort_o,
    input  phy_cmd_ready_i, phy_done_i, phy_ack_i, phy_rdata_i, phy_arb_lost_i
  );

  modport slave (
    input  phy_cmd_o, phy_nack_o, phy_wdata_o, phy_cmd_valid_o, phy_abort_o,
    output phy_cmd_ready_i, phy_done_i, phy_ack_i, phy_rdata_i, phy_arb_lost_i
  );
endinterface

// File: rtl/tqvp_dlmiles_i2c_timeout.sv
// rtl/tqvp_dlmiles_i2c_timeout.sv - PHY-wait watchdog counter with single-cycle expire
module tqvp_dlmiles_i2c_timeout #(
  parameter int          TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i)   count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i)  count_q <= count_q + TIMEOUT_W'(1);
  end

  assign expire_o = en_i && (count_q == LAST);
endmodule

// File: rtl/tqvp_dlmiles_i2c_seq.sv
// rtl/tqvp_dlmiles_i2c_seq.sv - sequencer from TX/RX FIFO pair to byte-level I2C PHY
module tqvp_dlmiles_i2c_seq
  import tqvp_dlmiles_i2c_seq_pkg::*;
#(
  parameter int          TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       go_i,
  input  logic       abort_i,
  input  logic       clr_err_i,
  input  logic       stop_on_empty_i,
  input  logic       nack_abort_i,
  input  logic [8:0] i2c_txd_data_i,
  input  logic       i2c_txd_valid_i,
  output logic       i2c_txd_ready_o,
  output logic [7:0] i2c_rxd_data_o,
  output logic       i2c_rxd_valid_o,
  output logic       tx_flush_o,
  tqvp_dlmiles_i2c_seq_if.master phy,
  output logic       busy_o,
  output logic       done_o,
  output logic       st_nack_o,
  output logic       st_arb_lost_o,
  output logic       st_timeout_o
);
  state_e   state_q, state_d;
  phy_req_t req_q, req_d;
  logic     abort_q;
  logic     tmo_expire;
  logic     rx_push, flush_set, abort_set, done_set, nack_set, arb_set, tmo_set;

  tqvp_dlmiles_i2c_timeout #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n_i  (rst_n_i),
    .clr_i    (state_q == ST_ISSUE),
    .en_i     (state_q == ST_WAIT),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go_i && i2c_txd_valid_i) state_d = ST_ISSUE;
      ST_ISSUE: if (phy.phy_cmd_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (phy.phy_arb_lost_i) state_d = ST_IDLE;
        else if (phy.phy_done_i) begin
          case (req_q.cmd)
            CMD_START, CMD_READ: state_d = ST_FETCH;
            CMD_WRITE: state_d = (!phy.phy_ack_i && nack_abort_i) ? ST_ISSUE : ST_FETCH;
            default:   state_d = ST_IDLE;
          endcase
        end else if (tmo_expire) state_d = ST_IDLE;
      end
      ST_FETCH: state_d = (abort_q || i2c_txd_valid_i || stop_on_empty_i) ? ST_ISSUE : ST_HOLD;
      ST_HOLD: begin
        if (abort_q)              state_d = ST_ISSUE;
        else if (i2c_txd_valid_i) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d           = req_q;
    i2c_txd_ready_o = 1'b0;
    rx_push         = 1'b0;
    flush_set       = 1'b0;
    abort_set       = 1'b0;
    done_set        = 1'b0;
    nack_set        = 1'b0;
    arb_set         = 1'b0;
    tmo_set         = 1'b0;
    busy_o          = (state_q != ST_IDLE);
    phy.phy_cmd_valid_o = (state_q == ST_ISSUE);
    case (state_q)
      ST_IDLE: if (go_i && i2c_txd_valid_i) begin
        req_d.cmd  = CMD_START;
        req_d.nack = 1'b0;
      end
      ST_WAIT: begin
        if (phy.phy_arb_lost_i) begin
          arb_set   = 1'b1;
          flush_set = 1'b1;
        end else if (phy.phy_done_i) begin
          case (req_q.cmd)
            CMD_WRITE: if (!phy.phy_ack_i) begin
              nack_set = 1'b1;
              if (nack_abort_i) begin
                flush_set  = 1'b1;
                req_d.cmd  = CMD_STOP;
                req_d.nack = 1'b0;
              end
            end
            CMD_READ: rx_push  = 1'b1;
            CMD_STOP: done_set = 1'b1;
            default:  ;
          endcase
        end else if (tmo_expire) begin
          abort_set = 1'b1;
          flush_set = 1'b1;
          tmo_set   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (abort_q || (!i2c_txd_valid_i && stop_on_empty_i)) begin
          req_d.cmd  = CMD_STOP;
          req_d.nack = 1'b0;
        end else if (i2c_txd_valid_i) begin
          i2c_txd_ready_o = 1'b1;
          req_d           = decode_txd(i2c_txd_data_i);
        end
      end
      ST_HOLD: if (abort_q) begin
        req_d.cmd  = CMD_STOP;
        req_d.nack = 1'b0;
      end
      default: ;
    endcase
  end

  // Pulses are registered so they line up with the state change they report.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q           <= '0;
      abort_q         <= 1'b0;
      i2c_rxd_data_o  <= 8'h00;
      i2c_rxd_valid_o <= 1'b0;
      tx_flush_o      <= 1'b0;
      phy.phy_abort_o <= 1'b0;
      done_o          <= 1'b0;
      st_nack_o       <= 1'b0;
      st_arb_lost_o   <= 1'b0;
      st_timeout_o    <= 1'b0;
    end else begin
      req_q <= req_d;
      if (state_d == ST_IDLE)                  abort_q <= 1'b0;
      else if (abort_i && state_q != ST_IDLE)  abort_q <= 1'b1;
      if (rx_push) i2c_rxd_data_o <= phy.phy_rdata_i;
      i2c_rxd_valid_o <= rx_push;
      tx_flush_o      <= flush_set;
      phy.phy_abort_o <= abort_set;
      done_o          <= done_set;
      st_nack_o       <= nack_set | (st_nack_o     & ~clr_err_i);
      st_arb_lost_o   <= arb_set  | (st_arb_lost_o & ~clr_err_i);
      st_timeout_o    <= tmo_set  | (st_timeout_o  & ~clr_err_i);
    end
  end

  assign phy.phy_cmd_o   = req_q.cmd;
  assign phy.phy_wdata_o = req_q.wdata;
  assign phy.phy_nack_o  = req_q.nack;
endmodule

// File: tb/tb_tqvp_dlmiles_i2c_seq.sv
// tb/tb_tqvp_dlmiles_i2c_seq.sv - scoreboard bench for the I2C transaction sequencer
module tb_tqvp_dlmiles_i2c_seq;
  import tqvp_dlmiles_i2c_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, go, abort, clr_err, stop_on_empty, nack_abort;
  logic [8:0] txd_data;
  logic       txd_valid, txd_ready;
  logic [7:0] rxd_data;
  logic       rxd_valid, tx_flush, busy, done, st_nack, st_arb, st_tmo;

  tqvp_dlmiles_i2c_seq_if phy_if();

  tqvp_dlmiles_i2c_seq #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst_n_i         (rst_n),
    .go_i            (go),
    .abort_i         (abort),
    .clr_err_i       (clr_err),
    .stop_on_empty_i (stop_on_empty),
    .nack_abort_i    (nack_abort),
    .i2c_txd_data_i  (txd_data),
    .i2c_txd_valid_i (txd_valid),
    .i2c_txd_ready_o (txd_ready),
    .i2c_rxd_data_o  (rxd_data),
    .i2c_rxd_valid_o (rxd_valid),
    .tx_flush_o      (tx_flush),
    .phy             (phy_if),
    .busy_o          (busy),
    .done_o          (done),
    .st_nack_o       (st_nack),
    .st_arb_lost_o   (st_arb),
    .st_timeout_o    (st_tmo)
  );

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] wdata;
    logic       nack;
  } exp_cmd_t;

  int n_checks = 0, n_errors = 0;
  int pops = 0, flushes = 0, dones = 0, aborts = 0, phy_dones = 0;
  int cyc = 0, wait_start = 0, abort_cyc = 0;
  logic [8:0] fifo[$];
  exp_cmd_t   exp_cmd[$];
  logic [7:0] exp_rx[$];
  logic       ack_cfg = 1'b1, hang_write = 1'b0, arb_cfg = 1'b0;
  logic [7:0] rdata_cfg = 8'h3C;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask

  task automatic fifo_refresh();
    txd_valid = (fifo.size() != 0);
    txd_data  = txd_valid ? fifo[0] : 9'h000;
  endtask

  task automatic push(input logic [8:0] e);
    fifo.push_back(e);
    fifo_refresh();
  endtask

  task automatic exp_c(input logic [2:0] c, input logic [7:0] d, input logic n);
    exp_cmd.push_back(exp_cmd_t'{cmd: c, wdata: d, nack: n});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(name, busy, 0);
  endtask

  // TX FIFO model: pop on ready, FIFO reset on tx_flush.
  initial begin : fifo_model
    logic p, f;
    forever begin
      @(negedge clk);
      p = txd_ready;
      f = tx_flush;
      @(posedge clk);
      #1;
      if (p) begin
        if (fifo.size() != 0) void'(fifo.pop_front());
        pops++;
      end
      if (f) fifo.delete();
      fifo_refresh();
    end
  end

  // PHY model: accepts each command, completes it two cycles later unless hung.
  initial begin : phy_model
    logic [2:0] c;
    phy_if.phy_cmd_ready_i = 1'b0;
    phy_if.phy_done_i      = 1'b0;
    phy_if.phy_ack_i       = 1'b0;
    phy_if.phy_rdata_i     = 8'h00;
    phy_if.phy_arb_lost_i  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && phy_if.phy_cmd_valid_o) begin
        c = phy_if.phy_cmd_o;
        phy_if.phy_cmd_ready_i = 1'b1;
        @(negedge clk);
        phy_if.phy_cmd_ready_i = 1'b0;
        if (!(hang_write && c == CMD_WRITE)) begin
          @(negedge clk);
          phy_if.phy_done_i     = 1'b1;
          phy_if.phy_ack_i      = ack_cfg;
          phy_if.phy_rdata_i    = rdata_cfg;
          phy_if.phy_arb_lost_i = arb_cfg && (c == CMD_READ);
          phy_dones++;
          @(negedge clk);
          phy_if.phy_done_i     = 1'b0;
          phy_if.phy_arb_lost_i = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: compares every issued command and RX push against the queues.
  initial begin : monitor
    logic     prev_v;
    exp_cmd_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (phy_if.phy_cmd_valid_o && !prev_v) begin
          if (exp_cmd.size() == 0) unexpected("cmd_extra", phy_if.phy_cmd_o);
          else begin
            e = exp_cmd.pop_front();
            check("cmd_code", phy_if.phy_cmd_o, e.cmd);
            if (e.cmd == CMD_WRITE) check("cmd_wdata", phy_if.phy_wdata_o, e.wdata);
            if (e.cmd == CMD_READ)  check("cmd_nack", phy_if.phy_nack_o, e.nack);
          end
        end
        if (prev_v && !phy_if.phy_cmd_valid_o && busy) wait_start = cyc;
        if (rxd_valid) begin
          if (exp_rx.size() == 0) unexpected("rx_extra", rxd_data);
          else check("rx_data", rxd_data, exp_rx.pop_front());
        end
        if (txd_ready) check("pop_needs_valid", txd_valid, 1);
        if (done) dones++;
        if (tx_flush) flushes++;
        if (phy_if.phy_abort_o) begin
          aborts++;
          abort_cyc = cyc;
        end
      end
      prev_v = rst_n && phy_if.phy_cmd_valid_o;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    int p0, d0, f0, a0, pd;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; clr_err = 1'b0;
    stop_on_empty = 1'b1; nack_abort = 1'b0;
    txd_data = 9'h000; txd_valid = 1'b0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", phy_if.phy_cmd_valid_o, 0);
    check("rst_phy_cmd", phy_if.phy_cmd_o, 0);
    check("rst_status", {st_nack, st_arb, st_tmo}, 0);
    rst_n = 1'b1;
    tick(1);

    pulse_go();
    tick(2);
    check("go_empty_ignored", busy, 0);

    // Write A0, write 55, read-with-NACK, auto STOP.
    push(9'h0A0); push(9'h055); push(9'h101);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_WRITE, 8'hA0, 1'b0);
    exp_c(CMD_WRITE, 8'h55, 1'b0); exp_c(CMD_READ, 8'h00, 1'b1);
    exp_c(CMD_STOP, 8'h00, 1'b0);
    exp_rx.push_back(8'h3C);
    p0 = pops; d0 = dones; f0 = flushes;
    pulse_go();
    wait_idle("t1_idle");
    tick(2);
    check("t1_pops", pops - p0, 3);
    check("t1_done", dones - d0, 1);
    check("t1_flush", flushes - f0, 0);
    check("t1_cmds_left", exp_cmd.size(), 0);
    check("t1_rx_left", exp_rx.size(), 0);

    // NACK on first write with nack_abort: flush and STOP, nothing else popped.
    ack_cfg = 1'b0; nack_abort = 1'b1;
    push(9'h0A0); push(9'h077); push(9'h088);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_WRITE, 8'hA0, 1'b0);
    exp_c(CMD_STOP, 8'h00, 1'b0);
    p0 = pops; d0 = dones; f0 = flushes;
    pulse_go();
    wait_idle("t2_idle");
    tick(2);
    check("t2_pops", pops - p0, 1);
    check("t2_flush", flushes - f0, 1);
    check("t2_done", dones - d0, 1);
    check("t2_st_nack", st_nack, 1);
    check("t2_cmds_left", exp_cmd.size(), 0);
    pulse_clr();
    check("t2_clr_nack", st_nack, 0);
    ack_cfg = 1'b1; nack_abort = 1'b0;

    // HOLD the bus, refill, then abort.
    stop_on_empty = 1'b0;
    push(9'h034);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_WRITE, 8'h34, 1'b0);
    p0 = pops; d0 = dones;
    pulse_go();
    tick(20);
    check("t3_hold_busy", busy, 1);
    check("t3_hold_no_cmd", phy_if.phy_cmd_valid_o, 0);
    check("t3_cmds_a", exp_cmd.size(), 0);
    push(9'h012);
    exp_c(CMD_WRITE, 8'h12, 1'b0);
    tick(20);
    check("t3_cmds_b", exp_cmd.size(), 0);
    check("t3_hold_busy2", busy, 1);
    exp_c(CMD_STOP, 8'h00, 1'b0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_idle("t3_idle");
    tick(2);
    check("t3_done", dones - d0, 1);
    check("t3_pops", pops - p0, 2);
    check("t3_cmds_left", exp_cmd.size(), 0);
    stop_on_empty = 1'b1;

    // PHY never completes the write: timeout after 8 WAIT cycles.
    hang_write = 1'b1;
    push(9'h099);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_WRITE, 8'h99, 1'b0);
    a0 = aborts; f0 = flushes; d0 = dones;
    pulse_go();
    wait_idle("t4_idle");
    tick(2);
    check("t4_phy_abort", aborts - a0, 1);
    check("t4_abort_delay", abort_cyc - wait_start, 8);
    check("t4_st_timeout", st_tmo, 1);
    check("t4_flush", flushes - f0, 1);
    check("t4_no_done", dones - d0, 0);
    check("t4_cmds_left", exp_cmd.size(), 0);
    hang_write = 1'b0;

    // Arbitration loss together with done on a read: no push, no STOP.
    arb_cfg = 1'b1;
    push(9'h100);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_READ, 8'h00, 1'b0);
    f0 = flushes; d0 = dones;
    pulse_go();
    wait_idle("t5_idle");
    tick(2);
    check("t5_st_arb", st_arb, 1);
    check("t5_flush", flushes - f0, 1);
    check("t5_no_done", dones - d0, 0);
    check("t5_cmds_left", exp_cmd.size(), 0);
    arb_cfg = 1'b0;

    // clr_err in the same cycle as a new NACK: the set wins.
    ack_cfg = 1'b0;
    push(9'h05A);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_WRITE, 8'h5A, 1'b0);
    exp_c(CMD_STOP, 8'h00, 1'b0);
    pd = phy_dones;
    pulse_go();
    for (int i = 0; i < 1000 && phy_dones < pd + 2; i++) #1;
    check("t6_write_done_seen", phy_dones - pd, 2);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    wait_idle("t6_idle");
    check("t6_set_wins", st_nack, 1);
    pulse_clr();
    check("t6_cleared", {st_nack, st_arb, st_tmo}, 0);
    check("t6_cmds_left", exp_cmd.size(), 0);
    ack_cfg = 1'b1;

    // Asynchronous reset while waiting on the PHY.
    hang_write = 1'b1;
    push(9'h042);
    exp_c(CMD_START, 8'h00, 1'b0); exp_c(CMD_WRITE, 8'h42, 1'b0);
    pulse_go();
    for (int i = 0; i < 100 && exp_cmd.size() != 0; i++) @(negedge clk);
    tick(3);
    check("t7_in_wait", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_phy_cmd", {phy_if.phy_cmd_valid_o, phy_if.phy_cmd_o, phy_if.phy_wdata_o, phy_if.phy_nack_o}, 0);
    check("t7_rst_pulses", {txd_ready, rxd_valid, tx_flush, done, phy_if.phy_abort_o}, 0);
    check("t7_rst_status", {st_nack, st_arb, st_tmo}, 0);
    fifo.delete();
    fifo_refresh();
    tick(2);
    rst_n = 1'b1;
    hang_write = 1'b0;
    tick(2);
    check("t7_cmds_left", exp_cmd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
